// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands, decodes the RV32I ALU op, latency 1.
// Backpressure: holds while out_valid && !out_ready; a load-use hazard forces one bubble.
module id_ex_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc_in,
    input  logic [4:0]      exmem_rd,
    input  logic [4:0]      memwb_rd,
    input  logic            exmem_we,
    input  logic            memwb_we,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_operation,
    output logic [XLEN-1:0] input_data1,
    output logic [XLEN-1:0] input_data2,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            is_branch,
    output logic [2:0]      branch_funct3,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] rf);
        if (addr == 5'd0)                          return '0;
        else if (exmem_we && exmem_rd == addr)     return exmem_result;
        else if (memwb_we && memwb_rd == addr)     return memwb_result;
        else                                       return rf;
    endfunction

    function automatic logic [3:0] alu_from(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic            out_valid_q, reg_write_q, mem_read_q, mem_write_q, is_branch_q, illegal_q;
    logic [3:0]      alu_op_q;
    logic [XLEN-1:0] d1_q, d2_q, store_q, pc_q;
    logic [4:0]      rd_q;
    logic [2:0]      bf3_q;

    logic            reg_write_d, mem_read_d, mem_write_d, is_branch_d, illegal_d;
    logic [3:0]      alu_op_d;
    logic [XLEN-1:0] d1_d, d2_d, rs1_fwd, rs2_fwd;
    logic            load_use, accept;

    assign rs1_fwd  = fwd(rs1_addr, rs1_data);
    assign rs2_fwd  = fwd(rs2_addr, rs2_data);
    assign load_use = out_valid_q && mem_read_q && (rd_q != 5'd0) && in_valid &&
                      (rd_q == rs1_addr || rd_q == rs2_addr);
    assign in_ready = (!out_valid_q || out_ready) && !load_use;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        alu_op_d    = ALU_ADD;
        d1_d        = rs1_fwd;
        d2_d        = rs2_fwd;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        is_branch_d = 1'b0;
        illegal_d   = 1'b0;
        case (opcode)
            OPC_OP:    begin alu_op_d = alu_from(funct3, funct7_b5); reg_write_d = 1'b1; end
            OPC_OPIMM: begin
                alu_op_d    = alu_from(funct3, (funct3 == 3'b101) && funct7_b5);
                d2_d        = imm;
                reg_write_d = 1'b1;
            end
            OPC_LOAD:  begin d2_d = imm; mem_read_d = 1'b1; reg_write_d = 1'b1; end
            OPC_STORE: begin d2_d = imm; mem_write_d = 1'b1; end
            OPC_LUI:   begin d1_d = '0; d2_d = imm; reg_write_d = 1'b1; end
            OPC_AUIPC: begin d1_d = pc_in; d2_d = imm; reg_write_d = 1'b1; end
            OPC_BRANCH: begin
                is_branch_d = 1'b1;
                case (funct3[2:1])
                    2'b10:   alu_op_d = ALU_SLT;
                    2'b11:   alu_op_d = ALU_SLTU;
                    default: alu_op_d = ALU_SUB;
                endcase
            end
            OPC_JAL, OPC_JALR: begin d1_d = pc_in; d2_d = XLEN'(4); reg_write_d = 1'b1; end
            default:   begin illegal_d = 1'b1; alu_op_d = ALU_AND; end
        endcase
        // x0 is never a real destination, so it must not look like a writer to later forwarding.
        if (rd_addr == 5'd0) reg_write_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            is_branch_q <= 1'b0;
            bf3_q       <= '0;
            pc_q        <= RESET_PC;
            illegal_q   <= 1'b0;
        end else begin
            // A load-use stall with out_ready high leaves accept low, which drains to a bubble.
            if (flush)
                out_valid_q <= 1'b0;
            else if (!out_valid_q || out_ready)
                out_valid_q <= accept;
            if (accept) begin
                alu_op_q    <= alu_op_d;
                d1_q        <= d1_d;
                d2_q        <= d2_d;
                store_q     <= rs2_fwd;
                rd_q        <= rd_addr;
                reg_write_q <= reg_write_d;
                mem_read_q  <= mem_read_d;
                mem_write_q <= mem_write_d;
                is_branch_q <= is_branch_d;
                bf3_q       <= funct3;
                pc_q        <= pc_in;
                illegal_q   <= illegal_d;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_operation = alu_op_q;
    assign input_data1   = d1_q;
    assign input_data2   = d2_q;
    assign store_data    = store_q;
    assign rd_out        = rd_q;
    assign reg_write     = reg_write_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign is_branch     = is_branch_q;
    assign branch_funct3 = bf3_q;
    assign pc_out        = pc_q;
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/forwarding vector table plus stall, flush and reset sequences.
module tb_id_ex_stage;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk, rst_n, in_valid, in_ready, funct7_b5, exmem_we, memwb_we, flush, out_valid, out_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3, branch_funct3;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, rd_out;
    logic [31:0] rs1_data, rs2_data, imm, pc_in, exmem_result, memwb_result;
    logic [3:0]  alu_operation;
    logic [31:0] input_data1, input_data2, store_data, pc_out;
    logic        reg_write, mem_read, mem_write, is_branch, illegal;

    int checks = 0;
    int failures = 0;

    id_ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc_in(pc_in),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .exmem_result(exmem_result), .memwb_result(memwb_result), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_operation(alu_operation),
        .input_data1(input_data1), .input_data2(input_data2), .store_data(store_data),
        .rd_out(rd_out), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .branch_funct3(branch_funct3), .pc_out(pc_out), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1, rs2, rd, exrd, wbrd;
        logic [31:0] r1d, r2d, imm, pc, exres, wbres;
        logic        exw, wbw;
        logic [3:0]  eop;
        logic [31:0] ed1, ed2, esd;
        logic        erw, emr, emw, ebr, eill;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] im,
                                input logic [31:0] pc, input logic [3:0] eop, input logic [31:0] ed1,
                                input logic [31:0] ed2, input logic [31:0] esd, input logic erw,
                                input logic emr, input logic emw, input logic ebr, input logic eill);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.r1d = r1d; v.r2d = r2d; v.imm = im; v.pc = pc;
        v.exw = 1'b0; v.exrd = 5'd0; v.exres = 32'h0; v.wbw = 1'b0; v.wbrd = 5'd0; v.wbres = 32'h0;
        v.eop = eop; v.ed1 = ed1; v.ed2 = ed2; v.esd = esd;
        v.erw = erw; v.emr = emr; v.emw = emw; v.ebr = ebr; v.eill = eill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        opcode = v.opc; funct3 = v.f3; funct7_b5 = v.f7;
        rs1_addr = v.rs1; rs2_addr = v.rs2; rd_addr = v.rd;
        rs1_data = v.r1d; rs2_data = v.r2d; imm = v.imm; pc_in = v.pc;
        exmem_we = v.exw; exmem_rd = v.exrd; exmem_result = v.exres;
        memwb_we = v.wbw; memwb_rd = v.wbrd; memwb_result = v.wbres;
    endtask

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] LUI = 7'b0110111, AUI = 7'b0010111, BR = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;

    vec_t vt[$];
    vec_t v, lw, add_dep;

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        drive(mk(7'h0, 3'h0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pc_out", pc_out, RST_PC);
        chk("rst_alu_op", 32'(alu_operation), 32'd0);
        chk("rst_ctrl", {27'd0, reg_write, mem_read, mem_write, is_branch, illegal}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #3 rst_n = 1'b1;
        tick();

        vt.push_back(mk(OP, 3'b000, 0, 1, 2, 3, 5, 7, 0, 32'h10, 4'b0010, 5, 7, 7, 1, 0, 0, 0, 0));
        v = mk(OP, 3'b000, 1, 4, 2, 8, 9, 3, 0, 32'h14, 4'b0110, 100, 3, 3, 1, 0, 0, 0, 0);
        v.exw = 1; v.exrd = 4; v.exres = 100; v.wbw = 1; v.wbrd = 4; v.wbres = 50;
        vt.push_back(v);
        v.exw = 0; v.pc = 32'h18; v.ed1 = 50;
        vt.push_back(v);
        v.exw = 1; v.exrd = 0; v.wbrd = 0; v.rs1 = 0; v.pc = 32'h1c; v.ed1 = 0;
        vt.push_back(v);
        vt.push_back(mk(OPI, 3'b101, 1, 1, 0, 5, 32'h8000_0000, 0, 3, 32'h20, 4'b1101, 32'h8000_0000, 3, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(BR, 3'b110, 0, 1, 2, 4, 32'hFFFF_FFFF, 1, 32'h40, 32'h24, 4'b1011, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 1, 0));
        vt.push_back(mk(OPI, 3'b000, 1, 3, 0, 7, 10, 0, 32'hFFFF_FFFB, 32'h28, 4'b0010, 10, 32'hFFFF_FFFB, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(LD, 3'b010, 0, 2, 0, 5, 32'h100, 0, 8, 32'h2c, 4'b0010, 32'h100, 8, 0, 1, 1, 0, 0, 0));
        vt.push_back(mk(ST, 3'b010, 0, 2, 3, 5'h0c, 32'h100, 32'hdead, 4, 32'h30, 4'b0010, 32'h100, 4, 32'hdead, 0, 0, 1, 0, 0));
        vt.push_back(mk(LUI, 3'b101, 0, 5'h11, 5'h12, 9, 32'h1234, 32'h5678, 32'h1234_5000, 32'h34, 4'b0010, 0, 32'h1234_5000, 32'h5678, 1, 0, 0, 0, 0));
        vt.push_back(mk(AUI, 3'b000, 0, 0, 0, 10, 0, 0, 32'h1000, 32'h40, 4'b0010, 32'h40, 32'h1000, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(JAL, 3'b000, 0, 0, 0, 1, 0, 0, 32'h800, 32'h80, 4'b0010, 32'h80, 4, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(JALR, 3'b000, 0, 6, 0, 1, 32'h99, 0, 32'h10, 32'h84, 4'b0010, 32'h84, 4, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(OP, 3'b100, 0, 1, 2, 0, 32'hF0F0, 32'h0FF0, 0, 32'h44, 4'b0011, 32'hF0F0, 32'h0FF0, 32'h0FF0, 0, 0, 0, 0, 0));
        vt.push_back(mk(7'h7f, 3'b000, 0, 0, 0, 3, 0, 0, 0, 32'h48, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
        v = mk(OP, 3'b110, 0, 1, 7, 2, 1, 2, 0, 32'h4c, 4'b0001, 1, 32'h55, 32'h55, 1, 0, 0, 0, 0);
        v.wbw = 1; v.wbrd = 7; v.wbres = 32'h55;
        vt.push_back(v);
        vt.push_back(mk(OP, 3'b011, 0, 1, 2, 3, 1, 2, 0, 32'h50, 4'b1011, 1, 2, 2, 1, 0, 0, 0, 0));
        vt.push_back(mk(OP, 3'b101, 0, 1, 2, 3, 1, 2, 0, 32'h54, 4'b1100, 1, 2, 2, 1, 0, 0, 0, 0));
        vt.push_back(mk(OP, 3'b001, 0, 1, 2, 3, 1, 2, 0, 32'h58, 4'b1001, 1, 2, 2, 1, 0, 0, 0, 0));
        vt.push_back(mk(OP, 3'b010, 0, 1, 2, 3, 1, 2, 0, 32'h5c, 4'b1010, 1, 2, 2, 1, 0, 0, 0, 0));
        vt.push_back(mk(OP, 3'b111, 0, 1, 2, 3, 1, 2, 0, 32'h60, 4'b0000, 1, 2, 2, 1, 0, 0, 0, 0));
        vt.push_back(mk(OPI, 3'b001, 0, 1, 0, 3, 1, 0, 4, 32'h64, 4'b1001, 1, 4, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(OPI, 3'b010, 1, 1, 0, 3, 1, 0, 32'hFFFF_F800, 32'h68, 4'b1010, 1, 32'hFFFF_F800, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(OPI, 3'b111, 0, 1, 0, 3, 1, 0, 32'hFF, 32'h6c, 4'b0000, 1, 32'hFF, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(BR, 3'b000, 0, 1, 2, 0, 3, 3, 32'h8, 32'h70, 4'b0110, 3, 3, 3, 0, 0, 0, 1, 0));
        vt.push_back(mk(BR, 3'b101, 0, 1, 2, 0, 3, 4, 32'h8, 32'h74, 4'b1010, 3, 4, 4, 0, 0, 0, 1, 0));

        foreach (vt[i]) begin
            drive(vt[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_alu_op", i), 32'(alu_operation), 32'(vt[i].eop));
            chk($sformatf("v%0d_data1", i), input_data1, vt[i].ed1);
            chk($sformatf("v%0d_data2", i), input_data2, vt[i].ed2);
            chk($sformatf("v%0d_store_data", i), store_data, vt[i].esd);
            chk($sformatf("v%0d_rd_out", i), 32'(rd_out), 32'(vt[i].rd));
            chk($sformatf("v%0d_ctrl", i), {27'd0, reg_write, mem_read, mem_write, is_branch, illegal},
                {27'd0, vt[i].erw, vt[i].emr, vt[i].emw, vt[i].ebr, vt[i].eill});
            chk($sformatf("v%0d_bf3", i), 32'(branch_funct3), 32'(vt[i].f3));
            chk($sformatf("v%0d_pc_out", i), pc_out, vt[i].pc);
            tick();
        end

        // Load-use: LW x5 then ADD x6,x5,x1 with the load result arriving on MEM/WB.
        lw = mk(LD, 3'b010, 0, 2, 0, 5, 32'h100, 0, 0, 32'h200, 4'b0010, 0, 0, 0, 1, 1, 0, 0, 0);
        add_dep = mk(OP, 3'b000, 0, 5, 1, 6, 32'h999, 2, 0, 32'h204, 4'b0010, 32'h77, 2, 2, 1, 0, 0, 0, 0);
        add_dep.wbw = 1; add_dep.wbrd = 5; add_dep.wbres = 32'h77;
        drive(lw); in_valid = 1'b1;
        tick();
        chk("lu_load_valid", 32'(out_valid), 32'd1);
        drive(add_dep);
        #1;
        chk("lu_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_rd", 32'(rd_out), 32'd6);
        chk("lu_add_d1", input_data1, 32'h77);
        chk("lu_add_pc", pc_out, 32'h204);
        tick();

        // Backpressure for three cycles, then flush kills both held and incoming.
        drive(mk(OP, 3'b000, 0, 1, 2, 3, 11, 1, 0, 32'h300, 4'b0010, 11, 1, 1, 1, 0, 0, 0, 0));
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(mk(OP, 3'b000, 0, 1, 2, 4, 22, 2, 0, 32'h304, 4'b0010, 22, 2, 2, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_pc", k), pc_out, 32'h300);
            chk($sformatf("stall%0d_d1", k), input_data1, 32'd11);
            tick();
        end
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush_dropped", 32'(out_valid), 32'd0);

        // Flush during a load-use stall leaves nothing pending.
        drive(lw); in_valid = 1'b1;
        tick();
        drive(add_dep); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_lu_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush_lu_no_accept", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a load-use stall.
        drive(lw); in_valid = 1'b1;
        tick();
        drive(add_dep);
        #1;
        chk("rst_mid_stall", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc", pc_out, RST_PC);
        chk("arst_mem_read", 32'(mem_read), 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("arst_no_pending", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
